ecc_apb_sequencer: RTL

ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

---
 rtl/ecc_seq_pkg.sv | 33 +++
 rtl/ecc_apb_sequencer_if.sv | 47 ++++
 rtl/ecc_apb_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ecc_seq_pkg.sv
// Shared types and constants for the ECC APB write sequencer.
package ecc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  // ECC block register map
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_DATA_IN  = 8'h04;
  localparam logic [7:0] OFF_CW_WIDTH = 8'h08;
  localparam logic [7:0] OFF_NOISE    = 8'h0C;

  // CTRL opcodes
  localparam logic [1:0] OP_ENCODE = 2'd0;
  localparam logic [1:0] OP_DECODE = 2'd1;
  localparam logic [1:0] OP_FULL   = 2'd2;

  // Register offset for each write slot; CTRL goes last so it triggers the op
  function automatic logic [7:0] reg_offset(input logic [1:0] idx);
    case (idx)
      2'd0:    reg_offset = OFF_DATA_IN;
      2'd1:    reg_offset = OFF_CW_WIDTH;
      2'd2:    reg_offset = OFF_NOISE;
      default: reg_offset = OFF_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_sequencer_if.sv
// Request/response handshakes, APB master bus and ECC result lines.
interface ecc_apb_sequencer_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32
);
  logic                       req_valid;
  logic                       req_ready;
  logic [1:0]                 req_op;
  logic [1:0]                 req_width;
  logic [AMBA_WORD-1:0]       req_data;
  logic [AMBA_WORD-1:0]       req_noise;

  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;

  logic                       operation_done;
  logic [DATA_WIDTH-1:0]      data_out;
  logic [1:0]                 num_of_errors;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic [1:0]                 rsp_num_errors;
  logic                       rsp_timeout;

  modport master (
    input  req_valid, req_op, req_width, req_data, req_noise,
    output req_ready,
    output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    input  operation_done, data_out, num_of_errors,
    output rsp_valid, rsp_data, rsp_num_errors, rsp_timeout,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_width, req_data, req_noise,
    input  req_ready,
    input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    output operation_done, data_out, num_of_errors,
    input  rsp_valid, rsp_data, rsp_num_errors, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/ecc_apb_sequencer.sv
// Accepts one ECC request, programs the ECC block over APB (DATA_IN, WIDTH,
// NOISE, CTRL), waits for operation_done with a timeout, returns the result.
module ecc_apb_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_sequencer_if.master   bus
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                     r_state;
  logic [1:0]                 r_idx;
  logic [CNT_W-1:0]           r_cnt;
  logic [1:0]                 r_op;
  logic [1:0]                 r_width;
  logic [AMBA_WORD-1:0]       r_data;
  logic [AMBA_WORD-1:0]       r_noise;

  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic [AMBA_WORD-1:0]       r_pwdata;
  logic                       r_psel;
  logic                       r_penable;
  logic                       r_pwrite;
  logic                       r_req_ready;
  logic                       r_rsp_valid;
  logic [DATA_WIDTH-1:0]      r_rsp_data;
  logic [1:0]                 r_rsp_nerr;
  logic                       r_rsp_timeout;

  logic [1:0]                 w_next_idx;
  logic [AMBA_ADDR_WIDTH-1:0] w_next_addr;
  logic [AMBA_WORD-1:0]       w_next_wdata;

  // Address/data of the write slot following the current one
  always_comb begin
    w_next_idx   = r_idx + 2'd1;
    w_next_addr  = AMBA_ADDR_WIDTH'(reg_offset(w_next_idx));
    w_next_wdata = r_data;
    case (w_next_idx)
      2'd1:    w_next_wdata = AMBA_WORD'(r_width);
      2'd2:    w_next_wdata = r_noise;
      2'd3:    w_next_wdata = AMBA_WORD'(r_op);
      default: w_next_wdata = r_data;
    endcase
  end

  // Sequencer FSM with registered APB and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_cnt         <= '0;
      r_op          <= 2'd0;
      r_width       <= 2'd0;
      r_data        <= '0;
      r_noise       <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_nerr    <= 2'd0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (bus.req_valid && r_req_ready) begin
            r_op        <= bus.req_op;
            r_width     <= bus.req_width;
            r_data      <= bus.req_data;
            r_noise     <= bus.req_noise;
            r_idx       <= 2'd0;
            r_paddr     <= AMBA_ADDR_WIDTH'(OFF_DATA_IN);
            r_pwdata    <= bus.req_data;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_idx == 2'd3) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_cnt     <= '0;
            r_state   <= S_WAIT_DONE;
          end else begin
            r_idx     <= w_next_idx;
            r_paddr   <= w_next_addr;
            r_pwdata  <= w_next_wdata;
            r_penable <= 1'b0;
            r_state   <= S_SETUP;
          end
        end
        S_WAIT_DONE: begin
          // done takes priority over a timeout expiring in the same cycle
          if (bus.operation_done) begin
            r_rsp_data    <= bus.data_out;
            r_rsp_nerr    <= bus.num_of_errors;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_data    <= '0;
            r_rsp_nerr    <= 2'd0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.PADDR          = r_paddr;
  assign bus.PWDATA         = r_pwdata;
  assign bus.PSEL           = r_psel;
  assign bus.PENABLE        = r_penable;
  assign bus.PWRITE         = r_pwrite;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_data       = r_rsp_data;
  assign bus.rsp_num_errors = r_rsp_nerr;
  assign bus.rsp_timeout    = r_rsp_timeout;

endmodule
